seq_gen_scheduler: RTL and testbench

- Controller that configures and sequences a programmable serial bit-pattern generator.
- Holds the pattern, length and repeat count in shadow registers and runs the pattern on a start pulse.
- Emits one pattern bit per step on dout with a valid strobe, and reports busy/done.
- Sits between the control logic (start/abort/config) and any block consuming a serial test sequence.

---
 rtl/seq_gen_pkg.sv | 22 ++
 rtl/seq_gen_prescaler.sv | 31 +++
 rtl/seq_gen_scheduler.sv | 174 +++++++++++++++++
 tb/tb_seq_gen_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial sequence generator scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_gen_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = $clog2(PAT_W_DEF);
    localparam int REP_W_DEF = 4;
    localparam int DIV_W_DEF = 4;

    // Power-up shadow config: sequence 0,0,1,0,1,1 sent forever.
    localparam logic [PAT_W_DEF-1:0] DEF_PATTERN = 8'h34;
    localparam logic [LEN_W_DEF-1:0] DEF_LEN     = 3'd5;
    localparam logic [REP_W_DEF-1:0] DEF_REP     = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_gen_prescaler.sv
// Step-tick generator: one tick every div+1 clocks, restarted by clr.
// Latency: tick is combinational from the registered count.
// Backpressure: none; free-running outside of clr. Built only with SEQ_GEN_PRESCALE_EN.
`ifdef SEQ_GEN_PRESCALE_EN
module seq_gen_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == div);

    // Count up to div, then wrap; clr restarts the hold period from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/seq_gen_scheduler.sv
// Sequences a shadow-configured bit pattern onto dout/dout_vld, with repeat count and abort.
// Latency: first bit registered 1 cycle after start; all outputs registered.
// Backpressure: none; optional SEQ_GEN_PRESCALE_EN holds each bit for cfg_div+1 clocks.
module seq_gen_scheduler
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W),
    parameter int REP_W = 4,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [REP_W-1:0] cfg_rep,
`ifdef SEQ_GEN_PRESCALE_EN
    input  logic [DIV_W-1:0] cfg_div,
`endif
    input  logic             start,
    input  logic             abort,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [LEN_W-1:0] bit_idx
);

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pat_q, pat_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [REP_W-1:0] rep_q, rep_nxt;
    logic [REP_W:0]   rep_cnt, rep_cnt_nxt;
    logic [LEN_W-1:0] idx_nxt, idx_inc;
    logic             dout_nxt, vld_nxt, busy_nxt, done_nxt, err_nxt;
    logic             step_tick;

    assign idx_inc = bit_idx + 1'b1;

`ifdef SEQ_GEN_PRESCALE_EN
    logic [DIV_W-1:0] div_q, div_nxt;
    logic             presc_clr;

    // Hold period restarts with each new run and on abort.
    assign presc_clr = abort || ((state == ST_IDLE) && start);

    seq_gen_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .div  (div_q),
        .tick (step_tick)
    );
`else
    // One step per clock; DIV_W only matters when the prescaler is built in.
    assign step_tick = (DIV_W > 0);
`endif

    // Next-state and next-output decode; config writes are accepted only outside RUN.
    always_comb begin
        state_nxt   = state;
        pat_nxt     = pat_q;
        len_nxt     = len_q;
        rep_nxt     = rep_q;
        rep_cnt_nxt = rep_cnt;
        idx_nxt     = bit_idx;
        dout_nxt    = dout;
        vld_nxt     = dout_vld;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = cfg_err;
`ifdef SEQ_GEN_PRESCALE_EN
        div_nxt     = div_q;
`endif

        if (cfg_we) begin
            if (state == ST_RUN) begin
                err_nxt = 1'b1;
            end else begin
                pat_nxt = cfg_pattern;
                len_nxt = cfg_len;
                rep_nxt = cfg_rep;
                err_nxt = 1'b0;
`ifdef SEQ_GEN_PRESCALE_EN
                div_nxt = cfg_div;
`endif
            end
        end

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt   = ST_RUN;
                    idx_nxt     = '0;
                    dout_nxt    = pat_q[0];
                    vld_nxt     = 1'b1;
                    busy_nxt    = 1'b1;
                    rep_cnt_nxt = {{REP_W{1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    dout_nxt  = 1'b0;
                    vld_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (step_tick) begin
                    if (bit_idx < len_q) begin
                        idx_nxt  = idx_inc;
                        dout_nxt = pat_q[idx_inc];
                    end else if ((rep_q == '0) || (rep_cnt < {1'b0, rep_q})) begin
                        // Wrap straight back to bit 0 with no idle gap.
                        idx_nxt     = '0;
                        dout_nxt    = pat_q[0];
                        rep_cnt_nxt = (&rep_cnt) ? rep_cnt : rep_cnt + 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                        dout_nxt  = 1'b0;
                        vld_nxt   = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                dout_nxt  = 1'b0;
                vld_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, shadow config and registered outputs; reset restores the default config.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            pat_q    <= PAT_W'(DEF_PATTERN);
            len_q    <= LEN_W'(DEF_LEN);
            rep_q    <= REP_W'(DEF_REP);
            rep_cnt  <= '0;
            bit_idx  <= '0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
`ifdef SEQ_GEN_PRESCALE_EN
            div_q    <= '0;
`endif
        end else begin
            state    <= state_nxt;
            pat_q    <= pat_nxt;
            len_q    <= len_nxt;
            rep_q    <= rep_nxt;
            rep_cnt  <= rep_cnt_nxt;
            bit_idx  <= idx_nxt;
            dout     <= dout_nxt;
            dout_vld <= vld_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            cfg_err  <= err_nxt;
`ifdef SEQ_GEN_PRESCALE_EN
            div_q    <= div_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_seq_gen_scheduler.sv
// Scoreboard bench for seq_gen_scheduler: expected bit stream queued per run, monitor compares.
// Latency: first bit expected 1 cycle after start.
// Backpressure: none; abort/start/cfg timing driven directly.
module tb_seq_gen_scheduler;
    import seq_gen_pkg::*;

    localparam int PAT_W = 8;
    localparam int LEN_W = 3;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [REP_W-1:0] cfg_rep = '0;
`ifdef SEQ_GEN_PRESCALE_EN
    logic [3:0]       cfg_div = '0;
`endif
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             dout, dout_vld, busy, done, cfg_err;
    logic [LEN_W-1:0] bit_idx;

    always #5 clk = ~clk;

    seq_gen_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_rep     (cfg_rep),
`ifdef SEQ_GEN_PRESCALE_EN
        .cfg_div     (cfg_div),
`endif
        .start       (start),
        .abort       (abort),
        .dout        (dout),
        .dout_vld    (dout_vld),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .bit_idx     (bit_idx)
    );

    typedef struct packed {
        logic             b;
        logic [LEN_W-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   exp_done = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference view of the shadow config and error flag
    logic [PAT_W-1:0] m_pat = 8'h34;
    int               m_len = 5;
    int               m_rep = 0;
    logic             m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected stream: bit n of a run is pattern[n mod (len+1)]
    task automatic push_stream(input int k);
        for (int n = 0; n < k; n++) begin
            int   i;
            exp_t e;
            i = n % (m_len + 1);
            e.b = m_pat[i];
            e.idx = LEN_W'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic cfg_write(input logic [PAT_W-1:0] p, input int l, input int r);
        cfg_pattern = p;
        cfg_len = LEN_W'(l);
        cfg_rep = REP_W'(r);
        cfg_we = 1'b1;
        tick(1);
        cfg_we = 1'b0;
        m_pat = p;
        m_len = l;
        m_rep = r;
        m_err = 1'b0;
        check("cfg_err_after_idle_write", cfg_err, m_err);
    endtask

    // k bits expected; optionally a config write plus a stray start in the 2nd cycle of RUN;
    // with do_abort the abort lands so exactly k bits are shown, otherwise the run ends by itself.
    task automatic run(input int k, input bit cfg_mid, input bit do_abort);
        int elapsed;
        int c;
        push_stream(k);
        if (!do_abort) exp_done++;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        elapsed = 0;
        if (cfg_mid) begin
            cfg_pattern = PAT_W'($urandom);
            cfg_len = LEN_W'($urandom);
            cfg_rep = REP_W'($urandom);
            cfg_we = 1'b1;
            start = 1'b1;
            tick(1);
            cfg_we = 1'b0;
            start = 1'b0;
            m_err = 1'b1;
            elapsed = 1;
        end
        if (do_abort) begin
            tick(k - 1 - elapsed);
            abort = 1'b1;
            tick(1);
            abort = 1'b0;
        end else begin
            c = 0;
            while (busy && c < k + 10) begin
                tick(1);
                c++;
            end
            check("run_terminates", busy, 1'b0);
        end
        tick(2);
        check("bits_drained", exp_q.size(), 0);
        check("done_drained", exp_done, 0);
        check("cfg_err_model", cfg_err, m_err);
        check("idle_vld", dout_vld, 1'b0);
    endtask

    // Monitor: every valid bit must match the head of the expected queue
    always @(negedge clk) begin
        if (rst) begin
            check("busy_tracks_vld", busy, dout_vld);
            if (dout_vld) begin
                check("bit_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("dout", dout, e.b);
                    check("bit_idx", bit_idx, e.idx);
                end
            end
            if (done) begin
                check("done_expected", exp_done > 0, 1'b1);
                if (exp_done > 0) begin
                    exp_done--;
                    check("done_after_last_bit", exp_q.size(), 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_dout", dout, 1'b0);
        check("rst_vld", dout_vld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_bit_idx", bit_idx, 0);
        tick(2);
        rst = 1'b1;
        tick(1);

        // Default config runs forever until abort
        run(20, 1'b0, 1'b1);

        // Finite run: 0xA5, 8 bits, twice
        cfg_write(8'hA5, 7, 2);
        run(16, 1'b0, 1'b0);

        // Abort on the 4th bit, then a fresh run starts from bit 0
        run(4, 1'b0, 1'b1);
        run(16, 1'b0, 1'b0);

        // Config write and start while running are ignored, error flag is sticky
        cfg_write(8'h5A, 3, 0);
        run(12, 1'b1, 1'b1);
        cfg_write(8'hC3, 4, 2);
        run(10, 1'b0, 1'b0);

        // One-bit sequence repeated three times
        cfg_write(8'h01, 0, 3);
        run(3, 1'b0, 1'b0);

        // start together with abort in IDLE is dropped
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 1'b0);
        check("start_abort_vld", dout_vld, 1'b0);
        tick(2);

        // Randomized runs
        for (int it = 0; it < 30; it++) begin
            int  total;
            int  k;
            bit  ab;
            bit  cm;
            cfg_write(PAT_W'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            if (m_rep == 0) begin
                ab = 1'b1;
                k = int'($urandom_range(1, 24));
            end else begin
                total = m_rep * (m_len + 1);
                ab = (total > 1) && ($urandom_range(0, 2) == 0);
                k = ab ? int'($urandom_range(1, total - 1)) : total;
            end
            cm = (k >= 2) && ($urandom_range(0, 3) == 0);
            run(k, cm, ab);
        end

        // Reset mid-run returns to IDLE at once and restores the default config
        cfg_write(8'hFF, 7, 0);
        push_stream(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_dout", dout, 1'b0);
        check("midrst_vld", dout_vld, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_bit_idx", bit_idx, 0);
        check("midrst_bits_seen", exp_q.size(), 0);
        exp_q.delete();
        m_pat = 8'h34;
        m_len = 5;
        m_rep = 0;
        m_err = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        run(13, 1'b0, 1'b1);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_done_pending", exp_done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
